// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and depth constants.
package fifo_pkg;

    localparam int unsigned CONV_W       = 32;
    localparam int unsigned ADDRESS_SIZE = 4;
    localparam int unsigned DEPTH        = 2 ** ADDRESS_SIZE;

    // Narrower values are zero-extended into CONV_W; the leading zeros leave the result unchanged.
    function automatic logic [CONV_W-1:0] gray_to_binary(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray converter.
module binary_to_gray
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    assign gray_c = WIDTH'(bin2gray(CONV_W'(bin)));

endmodule

// File: rtl/sync_n_stage.sv
// STAGES-deep multi-bit synchronizer with synchronous active-low reset.
module sync_n_stage #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/w_ptr_ctrl_lvl.sv
// Write-domain pointer controller: Gray/binary write pointers, synchronized read pointer,
// registered fill level, full/almost-full flags and a sticky overflow flag.
module w_ptr_ctrl_lvl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AF_THRESHOLD = 14
) (
    input  logic                  w_clk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic                  w_ovf_clr,
    input  logic [ADDRESS_SIZE:0] r_ptr,
    output logic [ADDRESS_SIZE:0] w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDRESS_SIZE:0] w_level,
    output logic                  w_overflow
);

    localparam int unsigned PW = ADDRESS_SIZE + 1;

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] rq_gray;
    logic [PW-1:0] rq_bin;
    logic [PW-1:0] lvl_next;
    logic          wr_ok;
    logic          full_next;
    logic          af_next;

    sync_n_stage #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PW)
    ) u_rsync (
        .clk   (w_clk),
        .rst_n (wrst_n),
        .d     (r_ptr),
        .q     (rq_gray)
    );

    binary_to_gray #(
        .WIDTH (PW)
    ) u_b2g (
        .bin    (w_bnext),
        .gray_c (w_gnext)
    );

    assign wr_ok    = w_en & ~w_full;
    assign w_bnext  = w_bin + PW'(wr_ok);
    assign rq_bin   = PW'(gray_to_binary(CONV_W'(rq_gray)));
    assign lvl_next = w_bnext - rq_bin;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next = (w_gnext == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
    assign af_next   = (lvl_next >= PW'(AF_THRESHOLD));
    assign w_addr    = w_bin[ADDRESS_SIZE-1:0];

    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            w_bin         <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
            w_overflow    <= 1'b0;
        end else begin
            w_bin         <= w_bnext;
            w_ptr         <= w_gnext;
            w_full        <= full_next;
            w_almost_full <= af_next;
            w_level       <= lvl_next;
            // Set takes priority over clear on the same edge.
            if (w_en & w_full) begin
                w_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                w_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_w_ptr_ctrl_lvl.sv
// Directed self-checking bench for w_ptr_ctrl_lvl (ADDRESS_SIZE=3, SYNC_STAGES=2, AF_THRESHOLD=6).
module tb_w_ptr_ctrl_lvl;

    logic       w_clk = 1'b0;
    logic       wrst_n;
    logic       w_en;
    logic       w_ovf_clr;
    logic [3:0] r_ptr;
    logic [3:0] w_ptr;
    logic [2:0] w_addr;
    logic       w_full;
    logic       w_almost_full;
    logic [3:0] w_level;
    logic       w_overflow;

    int n_checks = 0;
    int n_errors = 0;

    w_ptr_ctrl_lvl #(
        .ADDRESS_SIZE (3),
        .SYNC_STAGES  (2),
        .AF_THRESHOLD (6)
    ) dut (
        .w_clk         (w_clk),
        .wrst_n        (wrst_n),
        .w_en          (w_en),
        .w_ovf_clr     (w_ovf_clr),
        .r_ptr         (r_ptr),
        .w_ptr         (w_ptr),
        .w_addr        (w_addr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    always #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ptr, input logic [2:0] addr,
                             input logic [3:0] lvl, input logic full, input logic af,
                             input logic ovf);
        check({tag, " w_ptr"},  32'(w_ptr), 32'(ptr));
        check({tag, " w_addr"}, 32'(w_addr), 32'(addr));
        check({tag, " w_level"}, 32'(w_level), 32'(lvl));
        check({tag, " w_full"}, 32'(w_full), 32'(full));
        check({tag, " w_af"},   32'(w_almost_full), 32'(af));
        check({tag, " w_ovf"},  32'(w_overflow), 32'(ovf));
    endtask

    initial begin
        // 1. Reset with w_en active and a non-zero read pointer.
        wrst_n = 1'b0; w_en = 1'b1; w_ovf_clr = 1'b0; r_ptr = 4'b0101;
        step();
        step();
        check_all("reset", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 2. Fill 8 entries with the read pointer at zero.
        wrst_n = 1'b1; r_ptr = 4'b0000; w_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("fill addr%0d", k), 32'(w_addr), 32'(k - 1));
            step();
            check($sformatf("fill lvl%0d", k), 32'(w_level), 32'(k));
            check($sformatf("fill af%0d", k), 32'(w_almost_full), 32'(k >= 6));
            check($sformatf("fill full%0d", k), 32'(w_full), 32'(k == 8));
        end
        check("fill w_ptr", 32'(w_ptr), 32'(4'b1100));

        // 3. Overflow attempts, then clear with and without a concurrent overflow.
        step();
        check_all("ovf1", 4'b1100, 3'd0, 4'd8, 1'b1, 1'b1, 1'b1);
        step();
        check_all("ovf2", 4'b1100, 3'd0, 4'd8, 1'b1, 1'b1, 1'b1);
        w_ovf_clr = 1'b1;
        step();
        check("ovf set_wins", 32'(w_overflow), 32'd1);
        w_en = 1'b0;
        step();
        check("ovf cleared", 32'(w_overflow), 32'd0);
        w_ovf_clr = 1'b0;

        // 4. Release: read pointer to 2, then 3.
        r_ptr = 4'b0011;
        step();
        check("rel e1 full", 32'(w_full), 32'd1);
        step();
        check("rel e2 full", 32'(w_full), 32'd1);
        step();
        check_all("rel e3", 4'b1100, 3'd0, 4'd6, 1'b0, 1'b1, 1'b0);
        r_ptr = 4'b0010;
        step();
        step();
        check("rel2 e2 lvl", 32'(w_level), 32'd6);
        step();
        check_all("rel2 e3", 4'b1100, 3'd0, 4'd5, 1'b0, 1'b0, 1'b0);

        // 5. Wrap: drain to 8, write up to 15, read to 12, then write across the wrap.
        r_ptr = 4'b1100;
        step(); step(); step();
        check_all("wrap drained", 4'b1100, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        w_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("wrap lvl%0d", k), 32'(w_level), 32'(k));
            check($sformatf("wrap addr%0d", k), 32'(w_addr), 32'(k));
            check($sformatf("wrap full%0d", k), 32'(w_full), 32'd0);
        end
        check_all("wrap at15", 4'b1000, 3'd7, 4'd7, 1'b0, 1'b1, 1'b0);
        w_en = 1'b0; r_ptr = 4'b1010;
        step(); step(); step();
        check_all("wrap read12", 4'b1000, 3'd7, 4'd3, 1'b0, 1'b0, 1'b0);
        w_en = 1'b1;
        step();
        check_all("wrap to0", 4'b0000, 3'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        step();
        check_all("wrap to1", 4'b0001, 3'd1, 4'd5, 1'b0, 1'b0, 1'b0);

        // 6. Fill to full, overflow, then a single reset edge mid-operation.
        step(); step();
        check("mid pre full", 32'(w_full), 32'd0);
        step();
        check_all("mid full", 4'b0110, 3'd4, 4'd8, 1'b1, 1'b1, 1'b0);
        step();
        check("mid ovf", 32'(w_overflow), 32'd1);
        wrst_n = 1'b0; r_ptr = 4'b0000;
        step();
        check_all("mid reset", 4'b0000, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        wrst_n = 1'b1;
        step();
        w_en = 1'b0;
        check_all("post write", 4'b0001, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        check_all("post idle", 4'b0001, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/w_ptr_ctrl_lvl.md
Name: w_ptr_ctrl_lvl

Overview:
Write-domain pointer and flag controller for the asynchronous dual-clock FIFO. It is the parametrised successor of the current write-side block.
- Keeps the binary/Gray write pointers and brings the read Gray pointer in through a configurable-depth synchronizer.
- Adds a registered fill level, a programmable almost-full flag and a sticky overflow flag.
- Sits between the write-side user interface and the dual-port RAM, and exports the Gray write pointer to the read domain.

Parameters:
- ADDRESS_SIZE, 4, RAM address width; FIFO depth = 2**ADDRESS_SIZE; legal range ≥ 2.
- SYNC_STAGES, 2, flop count in the r_ptr synchronizer; legal range ≥ 2.
- AF_THRESHOLD, 14, w_almost_full asserts when the level is ≥ this value; legal range 1..2**ADDRESS_SIZE.

Ports:
- w_clk  in  1  write clock; the single clock of the block.
- wrst_n  in  1  reset; synchronous, active-low.
- w_en  in  1  write request.
- w_ovf_clr  in  1  clears w_overflow.
- r_ptr  in  ADDRESS_SIZE+1  Gray read pointer from the read domain (asynchronous to w_clk).
- w_ptr  out  ADDRESS_SIZE+1  registered Gray write pointer, sent to the read domain.
- w_addr  out  ADDRESS_SIZE  RAM write address = low bits of the binary pointer.
- w_full  out  1  registered full flag.
- w_almost_full  out  1  registered almost-full flag.
- w_level  out  ADDRESS_SIZE+1  registered occupancy, range 0..2**ADDRESS_SIZE.
- w_overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: when wrst_n=0 at a posedge of w_clk, all registers clear together: binary pointer, w_ptr, synchronizer stages, w_full, w_almost_full, w_level, w_overflow. All outputs read 0 after that edge. w_en and w_ovf_clr are ignored while reset is held. Reset applied mid-operation (full, overflowed) gives the same result.
- Write acceptance: wr_ok = w_en & !w_full.
  - w_bnext = w_bin + wr_ok, wrapping modulo 2**(ADDRESS_SIZE+1).
  - w_gnext = binary_to_gray(w_bnext).
  - Binary and Gray registers load on every non-reset edge.
  - w_addr is taken from the register output, so the current write goes to w_addr and the address advances one cycle later.
- Synchronizer: r_ptr passes through SYNC_STAGES flops to give rq_gray. rq_bin = gray_to_binary(rq_gray).
- Level: lvl_next = w_bnext − rq_bin, computed modulo 2**(ADDRESS_SIZE+1). w_level is registered from lvl_next.
  - The level is pessimistic: it lags reads by SYNC_STAGES+1 cycles and is never an underestimate.
- Full: full_next is true when all of the following hold:
  - w_gnext MSB differs from rq_gray MSB;
  - w_gnext MSB−1 differs from rq_gray MSB−1;
  - all remaining bits are equal.

  full_next is equivalent to lvl_next == 2**ADDRESS_SIZE, and w_full is its registered value. w_full asserts on the same edge as the final accepted write.
- Full release: w_full deasserts SYNC_STAGES+1 w_clk edges after r_ptr advances.
- Almost-full: w_almost_full is the registered value of (lvl_next ≥ AF_THRESHOLD). With AF_THRESHOLD = depth it mirrors w_full.
- Overflow: an overflow event is w_en & w_full at a posedge.
  - The event sets w_overflow at that edge.
  - w_ovf_clr clears w_overflow at the next edge.
  - If set and clear occur on the same edge, set wins and w_overflow stays 1.
  - An overflow never changes the pointers.
- Wrap: the binary pointer rolls from 2**(ADDRESS_SIZE+1)−1 to 0 with no special handling, and the Gray code changes by one bit.
- Flag consistency: full and level stay consistent across the wrap.

Decomposition:
- Package fifo_pkg holds:
  - gray_to_binary function, a generic XOR-prefix loop;
  - bin2gray function;
  - localparam DEPTH = 2**ADDRESS_SIZE, usable via the package.
- Keep the existing binary_to_gray module for w_gnext.
- One new sub-module, sync_n_stage: a SYNC_STAGES-deep, WIDTH-wide synchronizer with synchronous active-low reset. It replaces two_ff_synchronizer here.
- The level, flag and overflow logic stays in the top module.

Test Plan:
All scenarios use ADDRESS_SIZE=3, SYNC_STAGES=2, AF_THRESHOLD=6.
1. Reset: drive wrst_n=0 for 2 edges with w_en=1 and r_ptr=4'b0101 → w_ptr=0, w_addr=0, w_level=0, w_full=0, w_almost_full=0, w_overflow=0; pointer does not move.
2. Fill: hold r_ptr=0 and w_en=1 for 8 edges → w_addr steps 0..7 and w_level steps 1..8. w_almost_full rises at edge 6. w_full rises at edge 8. Final w_ptr=4'b1100 (gray of 8).
3. Overflow: with the FIFO full, hold w_en=1 for 2 more edges → w_ptr stays 4'b1100 and w_overflow=1. Then pulse w_ovf_clr together with w_en=1 → w_overflow stays 1. Then pulse w_ovf_clr with w_en=0 → w_overflow=0.
4. Release: from full, set r_ptr=4'b0011 (gray of 2) → after exactly 3 edges, w_full=0 and w_level=6, with w_almost_full still 1. Then set r_ptr=4'b0010 (gray of 3) → after 3 edges, w_level=5 and w_almost_full=0.
5. Wrap: interleave writes with r_ptr updates so that w_bin goes 15→0 → w_ptr goes 4'b1000→4'b0000, w_addr goes 7→0, and w_level is correct throughout with no false w_full.
6. Mid-operation reset: in the full and overflowed state, apply one edge with wrst_n=0 → all outputs are 0 on the next edge. After release, a single write gives w_level=1 and w_addr=1.
